// File: rtl/locked_sec_pkg.sv
// Shared FSM type and H-matrix helpers for the key-locked SEC codec.
// Helpers work on the widest supported word; narrower callers zero-extend.
package locked_sec_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_CHK_W  = 8;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ARMED} fsm_state_e;

  // H column of data bit i: the i-th integer >= 3 that is not a power of two.
  function automatic int col_of(input int i);
    int c;
    c = i + 3;
    for (int k = 2; k < 16; k++) begin
      if (c >= (1 << k)) c++;
    end
    return c;
  endfunction

  function automatic logic [MAX_CHK_W-1:0] parity(input logic [MAX_DATA_W-1:0] d);
    logic [MAX_CHK_W-1:0] p;
    int c;
    p = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      c = col_of(i);
      if (d[i]) p = p ^ c[MAX_CHK_W-1:0];
    end
    return p;
  endfunction

  function automatic bit chk_w_ok(input int data_w, input int chk_w);
    return (2 ** chk_w >= data_w + chk_w + 1) &&
           (data_w <= MAX_DATA_W) && (chk_w <= MAX_CHK_W);
  endfunction

endpackage

// File: rtl/sec_syndrome_corr.sv
// Combinational syndrome decode: flips the data bit whose H column matches,
// flags check-bit hits (power-of-two syndromes) and unmatched syndromes.
module sec_syndrome_corr
  import locked_sec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 6
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [CHK_W-1:0]  syn_i,
  output logic [DATA_W-1:0] data_o,
  output logic              corr_o,
  output logic              unc_o
);

  logic [DATA_W-1:0] hit;
  logic              syn_nz;
  logic              syn_pow2;

  // Columns are never zero, so at most one hit and none for a clean word.
  for (genvar i = 0; i < DATA_W; i++) begin : g_col
    localparam int COL = col_of(i);
    assign hit[i] = (syn_i == COL[CHK_W-1:0]);
  end

  assign syn_nz   = |syn_i;
  assign syn_pow2 = syn_nz && ((syn_i & (syn_i - CHK_W'(1))) == '0);
  assign data_o   = data_i ^ hit;
  assign corr_o   = (|hit) || syn_pow2;
  assign unc_o    = syn_nz && !corr_o;

endmodule

// File: rtl/locked_sec_codec_pipe.sv
// Key-locked single-error-correcting codec with serial key load and a
// 2-stage valid/ready pipeline. Define SEC_ERR_CNT_EN for error counters.
module locked_sec_codec_pipe
  import locked_sec_pkg::*;
#(
  parameter int               DATA_W      = 32,
  parameter int               CHK_W       = 6,
  parameter int               KEY_W       = 2 * DATA_W,
  parameter logic [KEY_W-1:0] CORRECT_KEY = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_start,
  input  logic              key_shift,
  input  logic              key_bit,
  output logic              locked,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CHK_W-1:0]  chk_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr,
  output logic              err_unc
`ifdef SEC_ERR_CNT_EN
  ,
  output logic [15:0]       corr_cnt,
  output logic [15:0]       unc_cnt
`endif
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  if (!chk_w_ok(DATA_W, CHK_W) || (KEY_W != 2 * DATA_W)) begin : g_cfg_err
    $error("locked_sec_codec_pipe: CHK_W too small for DATA_W, or KEY_W != 2*DATA_W");
  end

  fsm_state_e        state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [KEY_W-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [CHK_W-1:0]  s1_syn_q;
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;
  logic              s2_corr_q, s2_unc_q;

  logic              s1_adv, s2_adv, accept, pipe_empty, fsm_open;
  logic [KEY_W-1:0]  ek;
  logic [DATA_W-1:0] d1, fix_data;
  logic [CHK_W-1:0]  syn;
  logic              fix_corr, fix_unc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    case (state_q)
      IDLE, ARMED: begin
        if (key_start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        // A restart outranks a shift arriving in the same cycle.
        if (key_start) begin
          count_d = '0;
        end else if (key_shift) begin
          shadow_d = {shadow_q[KEY_W-2:0], key_bit};
          count_d  = count_q + CNT_W'(1);
          if (count_q == CNT_W'(KEY_W - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          key_d   = shadow_q;
          state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      key_q    <= '0;
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign ek         = key_q ^ CORRECT_KEY;
  assign s2_adv     = !s2_valid_q || out_ready;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign fsm_open   = (state_q == IDLE) || (state_q == ARMED);
  assign in_ready   = rst_n && fsm_open && s1_adv;
  assign accept     = in_valid && in_ready;
  assign pipe_empty = !s1_valid_q && !s2_valid_q;

  assign d1  = data_in ^ ek[DATA_W-1:0];
  assign syn = chk_in ^ CHK_W'(parity(MAX_DATA_W'(d1)));

  sec_syndrome_corr #(
    .DATA_W(DATA_W),
    .CHK_W (CHK_W)
  ) u_corr (
    .data_i(s1_data_q),
    .syn_i (s1_syn_q),
    .data_o(fix_data),
    .corr_o(fix_corr),
    .unc_o (fix_unc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_corr_q  <= 1'b0;
      s2_unc_q   <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= accept;
      if (accept) begin
        s1_data_q <= d1;
        s1_syn_q  <= syn;
      end
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        s2_data_q <= fix_data ^ ek[KEY_W-1:DATA_W];
        s2_corr_q <= fix_corr;
        s2_unc_q  <= fix_unc;
      end
    end
  end

  assign locked    = (state_q != ARMED);
  assign out_valid = s2_valid_q;
  assign data_out  = s2_data_q;
  assign err_corr  = s2_corr_q;
  assign err_unc   = s2_unc_q;

`ifdef SEC_ERR_CNT_EN
  logic [15:0] corr_cnt_q, unc_cnt_q;
  logic        out_fire;

  assign out_fire = s2_valid_q && out_ready;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      if (out_fire && s2_corr_q && (corr_cnt_q != 16'hFFFF)) corr_cnt_q <= corr_cnt_q + 16'd1;
      if (out_fire && s2_unc_q && (unc_cnt_q != 16'hFFFF)) unc_cnt_q <= unc_cnt_q + 16'd1;
    end
  end

  assign corr_cnt = corr_cnt_q;
  assign unc_cnt  = unc_cnt_q;
`endif

endmodule

// File: tb/tb_locked_sec_codec_pipe.sv
// Scoreboard bench for locked_sec_codec_pipe: the driver queues hand-computed
// expectations, a monitor pops and compares on every output handshake.
module tb_locked_sec_codec_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_start = 1'b0, key_shift = 1'b0, key_bit = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] data_in = '0;
  logic [5:0]  chk_in = '0;
  logic        locked, in_ready, out_valid, err_corr, err_unc;
  logic [31:0] data_out;
`ifdef SEC_ERR_CNT_EN
  logic [15:0] corr_cnt, unc_cnt;
`endif

  locked_sec_codec_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_start(key_start),
    .key_shift(key_shift),
    .key_bit  (key_bit),
    .locked   (locked),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .chk_in   (chk_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .err_corr (err_corr),
    .err_unc  (err_unc)
`ifdef SEC_ERR_CNT_EN
    ,
    .corr_cnt (corr_cnt),
    .unc_cnt  (unc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        corr;
    logic        unc;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   model_corr = 0;
  int   model_unc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Check bits by walking the integers from 3 and skipping powers of two.
  function automatic logic [5:0] calc_chk(input logic [31:0] d);
    logic [5:0] p;
    int c;
    p = '0;
    c = 2;
    for (int i = 0; i < 32; i++) begin
      c++;
      while ((c & (c - 1)) == 0) c++;
      if (d[i]) p = p ^ 6'(c);
    end
    return p;
  endfunction

  // Monitor: sampled mid-cycle, after all drivers have settled.
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", data_out, hold_data);
        end
        hold_pend = out_valid && !out_ready;
        hold_data = data_out;
        if (out_valid && out_ready) begin
          check("out_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("data_out", data_out, e.data);
            check("err_corr", 32'(err_corr), 32'(e.corr));
            check("err_unc", 32'(err_unc), 32'(e.unc));
            if (e.lat) check("latency", 32'(cyc - e.acc), 32'd2);
            if (e.corr) model_corr++;
            if (e.unc) model_unc++;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [5:0] c, input logic [31:0] ed,
                      input logic ec, input logic eu, input bit lat);
    exp_t e;
    int   t;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    chk_in   = c;
    #1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("accept_in_time", 32'(in_ready), 32'd1);
    if (in_ready) begin
      e.data = ed;
      e.corr = ec;
      e.unc  = eu;
      e.acc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
  endtask

  // Called at a falling edge; shifts the key MSB first, one bit per cycle.
  task automatic shift_key(input logic [63:0] k);
    for (int i = 63; i >= 0; i--) begin
      key_shift = 1'b1;
      key_bit   = k[i];
      @(negedge clk);
    end
    key_shift = 1'b0;
  endtask

  task automatic wait_armed();
    int t;
    t = 0;
    while (locked && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("armed", 32'(locked), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    logic [5:0] ck_db;
    ck_db = calc_chk(DB);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_locked", 32'(locked), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_data", data_out, 32'd0);
    check("post_rst_flags", {30'd0, err_corr, err_unc}, 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_locked", 32'(locked), 32'd1);

    // Correct key, with a restart mid-load (restart drops the coincident shift).
    start_pulse();
    for (int i = 0; i < 10; i++) begin
      key_shift = 1'b1;
      key_bit   = 1'b1;
      @(negedge clk);
    end
    key_start = 1'b1;
    key_shift = 1'b1;
    key_bit   = 1'b1;
    #1;
    check("load_locked", 32'(locked), 32'd1);
    check("load_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    key_start = 1'b0;
    shift_key(64'h0);
    wait_armed();

    // Clean, data-bit, double, check-bit, zero and top-bit words back to back.
    send(DB, ck_db, DB, 1'b0, 1'b0, 1'b1);
    send(DB ^ 32'h0000_0100, ck_db, DB, 1'b1, 1'b0, 1'b1);
    send(DB ^ 32'h0400_0010, ck_db, 32'hDAADBEFF, 1'b0, 1'b1, 1'b1);
    send(DB, ck_db ^ 6'h04, DB, 1'b1, 1'b0, 1'b1);
    send(32'h0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(32'h9234_5678, calc_chk(32'h1234_5678), 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    idle();
    drain();

    // Backpressure: out_ready low for three cycles once two words are held.
    fork
      begin
        send(32'h1111_1111, calc_chk(32'h1111_1111), 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        send(32'h2222_2223, calc_chk(32'h2222_2222), 32'h2222_2222, 1'b1, 1'b0, 1'b0);
        send(32'h3333_3333, calc_chk(32'h3333_3333), 32'h3333_3333, 1'b0, 1'b0, 1'b0);
        send(32'h4444_4444, calc_chk(32'h4444_4444), 32'h4444_4444, 1'b0, 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Rekey with two words in flight; both leave with the old (correct) key.
    send(DB ^ 32'h0000_0100, ck_db, DB, 1'b1, 1'b0, 1'b1);
    fork
      send(32'h0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      begin
        @(negedge clk);
        key_start = 1'b1;
      end
    join
    @(negedge clk);
    key_start = 1'b0;
    in_valid  = 1'b0;
    #1;
    check("rekey_in_ready", 32'(in_ready), 32'd0);
    check("rekey_locked", 32'(locked), 32'd1);
    shift_key(64'h8000_0000_0000_0000);
    wait_armed();
    check("rekey_drained_first", 32'(sb.size()), 32'd0);

    // Wrong key on the output gate of data bit 31.
    send(32'h0, 6'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    send(DB, ck_db, 32'h5EAD_BEEF, 1'b0, 1'b0, 1'b1);
    idle();
    drain();
    check("wrong_key_locked", 32'(locked), 32'd0);

    // Wrong key on the input gate of data bit 0: the decoder repairs it.
    start_pulse();
    shift_key(64'h1);
    wait_armed();
    send(32'h0, 6'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle();
    drain();

`ifdef SEC_ERR_CNT_EN
    check("corr_cnt", 32'(corr_cnt), 32'(model_corr));
    check("unc_cnt", 32'(unc_cnt), 32'(model_unc));
`endif

    // Reset mid-transfer discards the word and the key.
    send(32'h1234_5678, calc_chk(32'h1234_5678), 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    model_corr = 0;
    model_unc  = 0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_locked", 32'(locked), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_still_empty", 32'(out_valid), 32'd0);
`ifdef SEC_ERR_CNT_EN
    check("midrst_corr_cnt", 32'(corr_cnt), 32'd0);
`endif

    // IDLE after reset runs with a cleared key register.
    send(DB ^ 32'h0000_0100, ck_db, DB, 1'b1, 1'b0, 1'b1);
    idle();
    drain();
    check("idle_after_rst_locked", 32'(locked), 32'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
